// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_gen
// Brief    : Streams fp32 FFT twiddle factors W_N^k for one radix-2 stage from
//            a quarter-wave cosine table. Optional macro TWIDDLE_INVERSE_EN adds
//            i_inverse to emit conjugate (inverse-FFT) twiddles.
// Revision : 1.0
// ============================================================================
module twiddle_gen #(
    parameter  int N_POINTS = 8,
    localparam int LOG2N    = $clog2(N_POINTS),
    localparam int SW       = $clog2(LOG2N) + 1,
    localparam int KW       = LOG2N - 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
`ifdef TWIDDLE_INVERSE_EN
    input  logic          i_inverse,
`endif
    input  logic          i_start,
    input  logic [SW-1:0] i_stage,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [31:0]   o_wr,
    output logic [31:0]   o_wi,
    output logic [KW-1:0] o_k,
    output logic          o_is_one,
    output logic          o_is_mj,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_err
);

    localparam int QTR  = N_POINTS / 4;
    localparam int HALF = N_POINTS / 2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Elaboration-only: Taylor-series cosine, then round-to-nearest-even into fp32.
    function automatic logic [31:0] cos_fp32(input int m);
        real x, x2, term, sum, a, mr, rem;
        int  e, q;
        x    = 2.0 * 3.14159265358979323846 * $itor(m) / $itor(N_POINTS);
        x2   = x * x;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i <= 24; i++) begin
            term = -term * x2 / $itor((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        if (sum < 1.0e-9) return 32'h0000_0000;
        a = sum;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e = e + 1; end
        while (a < 1.0)  begin a = a * 2.0; e = e - 1; end
        mr  = a * 8388608.0;
        q   = $rtoi(mr);
        rem = mr - $itor(q);
        if (rem > 0.5 || (rem == 0.5 && q[0])) q = q + 1;
        if (q == 16777216) begin q = 8388608; e = e + 1; end
        return {1'b0, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] fneg(input logic [31:0] v);
        return (v[30:0] == 31'h0) ? 32'h0000_0000 : {~v[31], v[30:0]};
    endfunction

    logic [31:0] w_tab [0:QTR];
    for (genvar m = 0; m <= QTR; m++) begin : g_tab
        localparam logic [31:0] C_VAL = cos_fp32(m);
        assign w_tab[m] = C_VAL;
    end

    state_t        state_q, state_d;
    logic          gen_q;
    logic [KW-1:0] j_q;
    logic [SW-1:0] stage_q;
    logic          idx_vld_q, idx_last_q;
    logic [KW-1:0] idx_k_q;
    logic          vld_q, last_q, one_q, mj_q, err_q;
    logic [31:0]   wr_q, wi_q;
    logic [KW-1:0] k_q;
`ifdef TWIDDLE_INVERSE_EN
    logic          inv_q;
`endif

    logic          w_en, w_accept, w_reject;
    logic [KW-1:0] w_mask, w_k, w_jq;
    logic [SW-1:0] w_shamt;
    logic [31:0]   w_wr, w_wi;
    logic          w_mj;

    assign w_en    = !vld_q | i_ready;
    assign w_mask  = ~({KW{1'b1}} << stage_q);
    assign w_shamt = SW'(KW) - stage_q;
    assign w_k     = (j_q & w_mask) << w_shamt;

    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_stage < SW'(LOG2N)) begin
                        state_d  = ST_RUN;
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (vld_q && i_ready && last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Quarter-wave folding: second quadrant reuses the table mirrored about N/4.
    always_comb begin
        w_wr = 32'h0;
        w_wi = 32'h0;
        w_jq = '0;
        if (idx_k_q <= KW'(QTR)) begin
            w_wr = w_tab[idx_k_q];
            w_wi = fneg(w_tab[KW'(QTR) - idx_k_q]);
        end else begin
            w_jq = idx_k_q - KW'(QTR);
            w_wr = fneg(w_tab[KW'(QTR) - w_jq]);
            w_wi = fneg(w_tab[w_jq]);
        end
`ifdef TWIDDLE_INVERSE_EN
        if (inv_q) w_wi = fneg(w_wi);
`endif
        w_mj = (w_wr == 32'h0) && (w_wi == 32'hbf80_0000);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gen_q      <= 1'b0;
            j_q        <= '0;
            stage_q    <= '0;
            idx_vld_q  <= 1'b0;
            idx_last_q <= 1'b0;
            idx_k_q    <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            one_q      <= 1'b0;
            mj_q       <= 1'b0;
            err_q      <= 1'b0;
            wr_q       <= 32'h0;
            wi_q       <= 32'h0;
            k_q        <= '0;
`ifdef TWIDDLE_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            err_q <= w_reject;
            if (w_accept) begin
                gen_q   <= 1'b1;
                j_q     <= '0;
                stage_q <= i_stage;
`ifdef TWIDDLE_INVERSE_EN
                inv_q   <= i_inverse;
`endif
            end else if (w_en && gen_q) begin
                j_q <= j_q + 1'b1;
                if (j_q == KW'(HALF - 1)) gen_q <= 1'b0;
            end
            if (w_en) begin
                idx_vld_q  <= gen_q;
                idx_k_q    <= w_k;
                idx_last_q <= gen_q && (j_q == KW'(HALF - 1));
                // Idle slots carry zeros so flags never glitch high without o_valid.
                vld_q  <= idx_vld_q;
                last_q <= idx_vld_q && idx_last_q;
                k_q    <= idx_vld_q ? idx_k_q : '0;
                wr_q   <= idx_vld_q ? w_wr : 32'h0;
                wi_q   <= idx_vld_q ? w_wi : 32'h0;
                one_q  <= idx_vld_q && (idx_k_q == '0);
                mj_q   <= idx_vld_q && w_mj;
            end
        end
    end

    assign o_valid  = vld_q;
    assign o_wr     = wr_q;
    assign o_wi     = wi_q;
    assign o_k      = k_q;
    assign o_is_one = one_q;
    assign o_is_mj  = mj_q;
    assign o_last   = last_q;
    assign o_busy   = (state_q == ST_RUN);
    assign o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_gen
// Brief    : Scoreboard bench for twiddle_gen (N=8; N=16 inverse instance when
//            TWIDDLE_INVERSE_EN is defined).
// Revision : 1.0
// ============================================================================
module tb_twiddle_gen;

    localparam int N_POINTS = 8;
    localparam int LOG2N    = 3;
    localparam int SW       = 3;
    localparam int KW       = 2;

    typedef struct packed {
        logic [31:0]   wr;
        logic [31:0]   wi;
        logic [KW-1:0] k;
        logic          one;
        logic          mj;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n, start, ready;
    logic [SW-1:0] stage;
    logic          valid, is_one, is_mj, last, busy, err;
    logic [31:0]   wr, wi;
    logic [KW-1:0] k;

    int    n_vec = 0;
    int    n_err = 0;
    int    n_pop = 0;
    word_t sb_q[$];

    always #5 clk = ~clk;

`ifdef TWIDDLE_INVERSE_EN
    logic        inv0 = 1'b0;
    logic        start16, inv16, valid16, one16, mj16, last16, busy16, err16;
    logic [2:0]  stage16, k16;
    logic [31:0] wr16, wi16;
`endif

    twiddle_gen #(.N_POINTS(N_POINTS)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
`ifdef TWIDDLE_INVERSE_EN
        .i_inverse(inv0),
`endif
        .i_start  (start),
        .i_stage  (stage),
        .i_ready  (ready),
        .o_valid  (valid),
        .o_wr     (wr),
        .o_wi     (wi),
        .o_k      (k),
        .o_is_one (is_one),
        .o_is_mj  (is_mj),
        .o_last   (last),
        .o_busy   (busy),
        .o_err    (err)
    );

`ifdef TWIDDLE_INVERSE_EN
    twiddle_gen #(.N_POINTS(16)) dut16 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_inverse(inv16),
        .i_start  (start16),
        .i_stage  (stage16),
        .i_ready  (1'b1),
        .o_valid  (valid16),
        .o_wr     (wr16),
        .o_wi     (wi16),
        .o_k      (k16),
        .o_is_one (one16),
        .o_is_mj  (mj16),
        .o_last   (last16),
        .o_busy   (busy16),
        .o_err    (err16)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference twiddles for N=8 written out by hand.
    function automatic word_t model_word(input int j, input int s, input bit is_last);
        word_t w;
        int    kk;
        kk = (j % (1 << s)) << (LOG2N - 1 - s);
        case (kk)
            0:       begin w.wr = 32'h3f800000; w.wi = 32'h00000000; end
            1:       begin w.wr = 32'h3f3504f3; w.wi = 32'hbf3504f3; end
            2:       begin w.wr = 32'h00000000; w.wi = 32'hbf800000; end
            default: begin w.wr = 32'hbf3504f3; w.wi = 32'hbf3504f3; end
        endcase
        w.k    = KW'(kk);
        w.one  = (kk == 0);
        w.mj   = (kk == 2);
        w.last = is_last;
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 32'(valid), 32'h0);
            end else begin
                check("wr",     wr,             sb_q[0].wr);
                check("wi",     wi,             sb_q[0].wi);
                check("k",      32'(k),         32'(sb_q[0].k));
                check("is_one", 32'(is_one),    32'(sb_q[0].one));
                check("is_mj",  32'(is_mj),     32'(sb_q[0].mj));
                check("last",   32'(last),      32'(sb_q[0].last));
                if (ready) begin
                    void'(sb_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic start_stage(input int s, input bit push);
        @(posedge clk); #1;
        start = 1'b1;
        stage = SW'(s);
        if (push) begin
            for (int j = 0; j < N_POINTS / 2; j++)
                sb_q.push_back(model_word(j, s, j == N_POINTS / 2 - 1));
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int cyc = 0;
        while ((sb_q.size() != 0 || busy) && cyc < 80) begin
            @(posedge clk); #1;
            if (toggle) ready = (cyc % 3 == 0);
            cyc++;
        end
        ready = 1'b1;
        check("drain_empty", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("watchdog expired, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        int base, cyc;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        stage = '0;
`ifdef TWIDDLE_INVERSE_EN
        start16 = 1'b0;
        inv16   = 1'b0;
        stage16 = '0;
`endif
        #12;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_wr",    wr,         32'h0);
        check("rst_wi",    wi,         32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_err",   32'(err),   32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // s=2: latency and value stream
        start_stage(2, 1'b1);
        check("busy_after_start", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("lat_edge1_valid", 32'(valid), 32'h0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 32'(valid), 32'h1);
        drain(1'b0);

        start_stage(1, 1'b1);
        drain(1'b0);
        start_stage(0, 1'b1);
        drain(1'b0);

        // backpressure 1,0,0,1,...
        start_stage(2, 1'b1);
        drain(1'b1);

        // out-of-range stage
        start_stage(3, 1'b0);
        check("err_pulse", 32'(err),  32'h1);
        check("err_busy",  32'(busy), 32'h0);
        @(posedge clk); #1;
        check("err_clear", 32'(err),  32'h0);
        repeat (3) @(posedge clk);

        // start while busy is ignored
        start_stage(2, 1'b1);
        start_stage(0, 1'b0);
        drain(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("idle_busy",  32'(busy),  32'h0);
        check("idle_valid", 32'(valid), 32'h0);

        // asynchronous reset mid-stream, then restart
        base = n_pop;
        start_stage(2, 1'b1);
        cyc = 0;
        while (n_pop < base + 2 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        check("pre_reset_words", 32'(n_pop - base), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_wr",    wr,         32'h0);
        check("midrst_wi",    wi,         32'h0);
        check("midrst_k",     32'(k),     32'h0);
        check("midrst_last",  32'(last),  32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_stage(2, 1'b1);
        drain(1'b0);

`ifdef TWIDDLE_INVERSE_EN
        begin
            int seen = 0;
            @(posedge clk); #1;
            start16 = 1'b1;
            stage16 = 3'd3;
            inv16   = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            cyc = 0;
            while (cyc < 30) begin
                @(negedge clk);
                cyc++;
                if (valid16 && k16 == 3'd4) begin
                    check("inv_k4_wr", wr16,        32'h00000000);
                    check("inv_k4_wi", wi16,        32'h3f800000);
                    check("inv_k4_mj", 32'(mj16),   32'h0);
                    seen++;
                end
                if (valid16 && k16 == 3'd2) begin
                    check("inv_k2_wr", wr16, 32'h3f3504f3);
                    check("inv_k2_wi", wi16, 32'h3f3504f3);
                    seen++;
                end
                if (valid16 && last16) break;
            end
            check("inv_seen", 32'(seen), 32'h2);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
